alu_pipe: RTL and testbench

- Parametrised successor to the single-cycle integer ALU in the Tomasulo core.
- Accepts one issued instruction per cycle from the ALU reservation station via a valid/ready handshake.
- Computes the result, branch/jump target and taken flag in one registered stage, then holds completed results in a DEPTH-entry FIFO until the CDB arbiter grants.
- Supports backpressure, ROB flush on mispredict, and the global rdy stall.

---
 rtl/alu_pipe_pkg.sv | 48 ++++
 rtl/alu_core.sv | 88 ++++++++
 rtl/alu_pipe.sv | 121 ++++++++++++
 tb/tb_alu_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and constants for the pipelined integer ALU.
// The 6-bit opcode space is only partly used; unused codes are broadcast as no-ops.
package alu_pipe_pkg;

    localparam int ROB_W_DEFAULT = 4;
    localparam int OPCODE_W      = 6;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD   = 6'd0,
        OP_SUB   = 6'd1,
        OP_XOR   = 6'd2,
        OP_OR    = 6'd3,
        OP_AND   = 6'd4,
        OP_SLL   = 6'd5,
        OP_SRL   = 6'd6,
        OP_SRA   = 6'd7,
        OP_SLT   = 6'd8,
        OP_SLTU  = 6'd9,
        OP_ADDI  = 6'd10,
        OP_XORI  = 6'd11,
        OP_ORI   = 6'd12,
        OP_ANDI  = 6'd13,
        OP_SLLI  = 6'd14,
        OP_SRLI  = 6'd15,
        OP_SRAI  = 6'd16,
        OP_SLTI  = 6'd17,
        OP_SLTIU = 6'd18,
        OP_LUI   = 6'd19,
        OP_AUIPC = 6'd20,
        OP_BEQ   = 6'd21,
        OP_BNE   = 6'd22,
        OP_BLT   = 6'd23,
        OP_BGE   = 6'd24,
        OP_BLTU  = 6'd25,
        OP_BGEU  = 6'd26,
        OP_JAL   = 6'd27,
        OP_JALR  = 6'd28
    } opcode_e;

    function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR};
    endfunction

    function automatic logic is_cond_branch(input logic [OPCODE_W-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opcode and operands in, {result, next_pc, taken, is_br} out.
// Unknown opcodes produce all-zero outputs so the ROB entry can still retire.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [XLEN-1:0]     lhs,
    input  logic [XLEN-1:0]     rhs,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     result,
    output logic [XLEN-1:0]     next_pc,
    output logic                taken,
    output logic                is_br
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt_r;
    logic [SHW-1:0]  shamt_i;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic            br_cond;

    assign shamt_r     = rhs[SHW-1:0];
    assign shamt_i     = imm[SHW-1:0];
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = lhs + imm;

    always_comb begin
        result  = '0;
        next_pc = '0;
        taken   = 1'b0;
        br_cond = 1'b0;
        is_br   = is_branch(opcode);
        case (opcode)
            OP_ADD:   result = lhs + rhs;
            OP_SUB:   result = lhs - rhs;
            OP_XOR:   result = lhs ^ rhs;
            OP_OR:    result = lhs | rhs;
            OP_AND:   result = lhs & rhs;
            OP_SLL:   result = lhs << shamt_r;
            OP_SRL:   result = lhs >> shamt_r;
            OP_SRA:   result = $unsigned($signed(lhs) >>> shamt_r);
            OP_SLT:   result = XLEN'($signed(lhs) < $signed(rhs));
            OP_SLTU:  result = XLEN'(lhs < rhs);
            OP_ADDI:  result = lhs + imm;
            OP_XORI:  result = lhs ^ imm;
            OP_ORI:   result = lhs | imm;
            OP_ANDI:  result = lhs & imm;
            OP_SLLI:  result = lhs << shamt_i;
            OP_SRLI:  result = lhs >> shamt_i;
            OP_SRAI:  result = $unsigned($signed(lhs) >>> shamt_i);
            OP_SLTI:  result = XLEN'($signed(lhs) < $signed(imm));
            OP_SLTIU: result = XLEN'(lhs < imm);
            OP_LUI:   result = imm;
            OP_AUIPC: result = pc_plus_imm;
            OP_BEQ:   br_cond = (lhs == rhs);
            OP_BNE:   br_cond = (lhs != rhs);
            OP_BLT:   br_cond = ($signed(lhs) < $signed(rhs));
            OP_BGE:   br_cond = ($signed(lhs) >= $signed(rhs));
            OP_BLTU:  br_cond = (lhs < rhs);
            OP_BGEU:  br_cond = (lhs >= rhs);
            OP_JAL: begin
                result  = pc_plus4;
                next_pc = pc_plus_imm;
                taken   = 1'b1;
            end
            OP_JALR: begin
                result  = pc_plus4;
                next_pc = jalr_sum & ~XLEN'(1);
                taken   = 1'b1;
            end
            default: ;
        endcase
        // Conditional branches report the taken flag as their rd value.
        if (is_cond_branch(opcode)) begin
            taken   = br_cond;
            result  = XLEN'(br_cond);
            next_pc = br_cond ? pc_plus_imm : pc_plus4;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: the issue stage writes the computed result straight into a DEPTH-entry
// FIFO whose head is broadcast on the CDB until the arbiter grants it.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROB_W = ROB_W_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [XLEN-1:0]     in_lhs,
    input  logic [XLEN-1:0]     in_rhs,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [ROB_W-1:0]    in_rob,
    output logic                cdb_valid,
    input  logic                cdb_ready,
    output logic [ROB_W-1:0]    cdb_rob,
    output logic [XLEN-1:0]     cdb_result,
    output logic [XLEN-1:0]     cdb_pc,
    output logic                cdb_taken,
    output logic                cdb_is_br
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  next_pc;
        logic             taken;
        logic             is_br;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             new_entry;
    entry_t             head;
    logic               push;
    logic               pop;

    alu_core #(.XLEN(XLEN)) u_core (
        .opcode  (in_opcode),
        .lhs     (in_lhs),
        .rhs     (in_rhs),
        .imm     (in_imm),
        .pc      (in_pc),
        .result  (new_entry.result),
        .next_pc (new_entry.next_pc),
        .taken   (new_entry.taken),
        .is_br   (new_entry.is_br)
    );
    assign new_entry.rob = in_rob;

    // Handshakes: a transfer happens only on a cycle where valid and ready are both high,
    // rdy is high and flush is low. in_ready depends on registered count alone, so a pop
    // frees a slot for the following cycle, never the same one.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign cdb_valid = (count_q != '0);
    assign push      = in_valid && in_ready && rdy && !flush;
    assign pop       = cdb_valid && cdb_ready && rdy && !flush;

    assign head       = mem_q[rd_ptr_q];
    assign cdb_rob    = cdb_valid ? head.rob     : '0;
    assign cdb_result = cdb_valid ? head.result  : '0;
    assign cdb_pc     = cdb_valid ? head.next_pc : '0;
    assign cdb_taken  = cdb_valid ? head.taken   : 1'b0;
    assign cdb_is_br  = cdb_valid ? head.is_br   : 1'b0;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rdy && flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed opcode table, multi-cycle FIFO/flush/rdy/reset sequences,
// and a randomized run scored against an arithmetic reference model with an expected queue.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int ROB_W = 4;
    localparam int DEPTH = 2;
    localparam int EW    = ROB_W + XLEN + XLEN + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [XLEN-1:0]   in_lhs, in_rhs, in_imm, in_pc;
    logic [ROB_W-1:0]  in_rob;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [ROB_W-1:0]  cdb_rob;
    logic [XLEN-1:0]   cdb_result, cdb_pc;
    logic              cdb_taken, cdb_is_br;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] lhs, rhs, imm, pc;
        logic [31:0] res, npc;
        logic        tk, br;
    } vec_t;
    vec_t vecs[$];

    alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_rob(cdb_rob),
        .cdb_result(cdb_result), .cdb_pc(cdb_pc), .cdb_taken(cdb_taken), .cdb_is_br(cdb_is_br)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_ent(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] cdb_now();
        return {cdb_rob, cdb_result, cdb_pc, cdb_taken, cdb_is_br};
    endfunction

    // Reference model: RISC-V style semantics from plain integer arithmetic.
    function automatic logic [EW-1:0] ref_calc(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] imm,
                                               input logic [31:0] pc, input logic [3:0] rob);
        logic [31:0] r, npc;
        logic        tk, br;
        int          sa, sb, si;
        int unsigned sh, shi;
        r = 0; npc = 0; tk = 0; br = 0;
        sa = a; sb = b; si = imm;
        sh = b % 32; shi = imm % 32;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_XOR:   r = a ^ b;
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_SLL:   r = a << sh;
            OP_SRL:   r = a >> sh;
            OP_SRA:   r = sa >>> sh;
            OP_SLT:   r = (sa < sb) ? 1 : 0;
            OP_SLTU:  r = (a < b) ? 1 : 0;
            OP_ADDI:  r = a + imm;
            OP_XORI:  r = a ^ imm;
            OP_ORI:   r = a | imm;
            OP_ANDI:  r = a & imm;
            OP_SLLI:  r = a << shi;
            OP_SRLI:  r = a >> shi;
            OP_SRAI:  r = sa >>> shi;
            OP_SLTI:  r = (sa < si) ? 1 : 0;
            OP_SLTIU: r = (a < imm) ? 1 : 0;
            OP_LUI:   r = imm;
            OP_AUIPC: r = pc + imm;
            OP_BEQ:   tk = (a == b);
            OP_BNE:   tk = (a != b);
            OP_BLT:   tk = (sa < sb);
            OP_BGE:   tk = (sa >= sb);
            OP_BLTU:  tk = (a < b);
            OP_BGEU:  tk = (a >= b);
            OP_JAL:   begin r = pc + 4; npc = pc + imm; tk = 1; br = 1; end
            OP_JALR:  begin r = pc + 4; npc = (a + imm) & 32'hFFFF_FFFE; tk = 1; br = 1; end
            default: ;
        endcase
        if (op >= OP_BEQ && op <= OP_BGEU) begin
            br  = 1;
            r   = tk ? 1 : 0;
            npc = tk ? pc + imm : pc + 4;
        end
        return {rob, r, npc, tk, br};
    endfunction

    // One clock: check outputs against the expected queue at negedge, update the model,
    // then return 1 time unit after the posedge so the caller can change inputs.
    task automatic cycle();
        logic do_push;
        @(negedge clk);
        chk_bit("in_ready", in_ready, exp_q.size() < DEPTH);
        chk_bit("cdb_valid", cdb_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk_ent("head", cdb_now(), exp_q[0]);
        else                   chk_ent("empty_out", cdb_now(), '0);
        if (!rst) begin
            exp_q.delete();
        end else if (rdy) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                do_push = in_valid && (exp_q.size() < DEPTH);
                if (cdb_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(ref_calc(in_opcode, in_lhs, in_rhs, in_imm, in_pc, in_rob));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        in_opcode = op; in_lhs = a; in_rhs = b; in_imm = imm; in_pc = pc; in_rob = rob;
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] res,
                           input logic [31:0] npc, input logic tk, input logic br);
        vec_t v;
        v.op = op; v.lhs = a; v.rhs = b; v.imm = imm; v.pc = pc;
        v.res = res; v.npc = npc; v.tk = tk; v.br = br;
        vecs.push_back(v);
    endtask

    initial begin
        //            op        lhs           rhs         imm           pc          res           npc          tk br
        add_vec(OP_ADDI,  32'd5,        32'd0,      32'hFFFF_FFFD, 32'h0,      32'd2,        32'h0,       0, 0);
        add_vec(OP_SRA,   32'h8000_0000, 32'd4,     32'h0,         32'h0,      32'hF800_0000, 32'h0,      0, 0);
        add_vec(OP_SRL,   32'h8000_0000, 32'd4,     32'h0,         32'h0,      32'h0800_0000, 32'h0,      0, 0);
        add_vec(OP_SLTIU, 32'd1,        32'd0,      32'hFFFF_FFFF, 32'h0,      32'd1,        32'h0,       0, 0);
        add_vec(OP_BLT,   32'hFFFF_FFFF, 32'd1,     32'h20,        32'h100,    32'd1,        32'h120,     1, 1);
        add_vec(OP_BGEU,  32'hFFFF_FFFF, 32'd1,     32'h20,        32'h100,    32'd1,        32'h120,     1, 1);
        add_vec(OP_JALR,  32'h203,      32'd0,      32'h0,         32'h100,    32'h104,      32'h202,     1, 1);
        add_vec(OP_SUB,   32'd3,        32'd5,      32'h0,         32'h0,      32'hFFFF_FFFE, 32'h0,      0, 0);
        add_vec(OP_LUI,   32'd7,        32'd9,      32'h1234_5000, 32'h40,     32'h1234_5000, 32'h0,      0, 0);
        add_vec(OP_AUIPC, 32'd0,        32'd0,      32'h2000,      32'h1000,   32'h3000,     32'h0,       0, 0);
        add_vec(OP_BEQ,   32'd1,        32'd2,      32'h40,        32'h200,    32'd0,        32'h204,     0, 1);
        add_vec(OP_JAL,   32'd0,        32'd0,      32'hFFFF_FFF0, 32'h300,    32'h304,      32'h2F0,     1, 1);
        add_vec(6'h3F,    32'd7,        32'd7,      32'h10,        32'h500,    32'd0,        32'h0,       0, 0);
        add_vec(OP_SLT,   32'hFFFF_FFFF, 32'd1,     32'h0,         32'h0,      32'd1,        32'h0,       0, 0);
        add_vec(OP_SLTU,  32'hFFFF_FFFF, 32'd1,     32'h0,         32'h0,      32'd0,        32'h0,       0, 0);
        add_vec(OP_SLLI,  32'd1,        32'd0,      32'h41,        32'h0,      32'd2,        32'h0,       0, 0);

        // reset
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_ready = 1'b0;
        drive_op(OP_ADD, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_cdb_valid", cdb_valid, 1'b0);
        chk_ent("rst_cdb_data", cdb_now(), '0);

        // opcode table, one op at a time
        foreach (vecs[i]) begin
            drive_op(vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].imm, vecs[i].pc, ROB_W'(i));
            in_valid = 1'b1; cdb_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk_ent($sformatf("vec%0d", i), cdb_now(),
                    {ROB_W'(i), vecs[i].res, vecs[i].npc, vecs[i].tk, vecs[i].br});
            cycle();
            chk_bit($sformatf("vec%0d_drained", i), cdb_valid, 1'b0);
        end

        // backpressure: three back-to-back ops with the CDB stalled
        cdb_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_op(OP_ADD, k, 32'd10, 0, 0, ROB_W'(k));
            chk_bit("bp_ready", in_ready, 1'b1);
            cycle();
        end
        drive_op(OP_ADD, 32'd2, 32'd10, 0, 0, 4'd2);
        chk_bit("bp_full", in_ready, 1'b0);
        cycle();
        chk_bit("bp_still_full", in_ready, 1'b0);
        cdb_ready = 1'b1;
        cycle();
        chk_bit("bp_reopen", in_ready, 1'b1);
        chk_bit("bp_valid", cdb_valid, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk_bit("bp_third_head", (cdb_rob == 4'd2) && (cdb_result == 32'd12), 1'b1);
        cycle();
        chk_bit("bp_drained", cdb_valid, 1'b0);

        // flush with a full FIFO, input valid and grant all high
        cdb_ready = 1'b0; in_valid = 1'b1;
        drive_op(OP_ADDI, 32'd1, 0, 32'd1, 0, 4'd5); cycle();
        drive_op(OP_ADDI, 32'd2, 0, 32'd1, 0, 4'd6); cycle();
        flush = 1'b1; cdb_ready = 1'b1;
        drive_op(OP_ADDI, 32'd3, 0, 32'd1, 0, 4'd7);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk_bit("flush_valid", cdb_valid, 1'b0);
        chk_bit("flush_ready", in_ready, 1'b1);
        cycle();
        chk_bit("flush_nothing_late", cdb_valid, 1'b0);

        // flush with one entry: the accepted-looking push must be dropped too
        cdb_ready = 1'b0; in_valid = 1'b1;
        drive_op(OP_XOR, 32'hF0, 32'h0F, 0, 0, 4'd8); cycle();
        flush = 1'b1; drive_op(OP_OR, 32'h1, 32'h2, 0, 0, 4'd9);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk_bit("flush1_valid", cdb_valid, 1'b0);
        cycle();

        // rdy low freezes everything, including an offered push
        cdb_ready = 1'b0; in_valid = 1'b1;
        drive_op(OP_ADDI, 32'd9, 0, 32'd1, 0, 4'd7); cycle();
        rdy = 1'b0; cdb_ready = 1'b1;
        drive_op(OP_ADDI, 32'd20, 0, 32'd1, 0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk_bit("freeze_hold", cdb_valid && (cdb_result == 32'd10) && (cdb_rob == 4'd7), 1'b1);
        end
        in_valid = 1'b0; rdy = 1'b1;
        cycle();
        chk_bit("freeze_popped", cdb_valid, 1'b0);

        // reset mid-stream
        cdb_ready = 1'b0; in_valid = 1'b1;
        drive_op(OP_JAL, 0, 0, 32'h40, 32'h80, 4'd1); cycle();
        drive_op(OP_LUI, 0, 0, 32'hABCD_0000, 0, 4'd2); cycle();
        in_valid = 1'b0; rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk_bit("midrst_valid", cdb_valid, 1'b0);
        chk_bit("midrst_ready", in_ready, 1'b1);
        chk_ent("midrst_data", cdb_now(), '0);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            cdb_ready = ($urandom_range(0, 9) < 6);
            in_opcode = 6'($urandom_range(0, 31));
            in_lhs    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            in_rhs    = ($urandom_range(0, 3) == 0) ? in_lhs : $urandom();
            in_imm    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            in_rob    = 4'($urandom_range(0, 15));
            cycle();
        end

        rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_ready = 1'b1;
        repeat (3) cycle();
        chk_bit("final_empty", cdb_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
